// File: rtl/rand_arbiter_if.sv
// rand_arbiter_if: request/result bundle between N requesters and rand_arbiter.
//   req      : per-requester request level, held until that requester's ack
//   min_flat : per-requester minimum, requester i at [i*WIDTH +: WIDTH]
//   max_flat : per-requester maximum, same packing
//   ack      : one-hot, one-cycle result strobe
//   rnd_out  : scaled random result, held until the next result
//   gnt_id   : index of the current or last granted requester
//   busy     : high while a request is in flight (grant through recovery)
interface rand_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int GW = $clog2(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] min_flat;
    logic [N*WIDTH-1:0] max_flat;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   rnd_out;
    logic [GW-1:0]      gnt_id;
    logic               busy;

    modport master (
        output req, min_flat, max_flat,
        input  ack, rnd_out, gnt_id, busy
    );

    modport slave (
        input  req, min_flat, max_flat,
        output ack, rnd_out, gnt_id, busy
    );
endinterface

// File: rtl/rand_arbiter.sv
// rand_arbiter: shares one 16-bit LFSR among N requesters with round-robin
// arbitration and reduces each drawn value into [min, max] of the granted
// requester using a 16-step restoring remainder (one bit per cycle).
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : rand_arbiter_if.slave (req/min/max in, ack/rnd_out/gnt_id/busy out)
// Latency: grant edge E0, remainder steps E1..E16, ack visible after E16,
// back in IDLE at E17, earliest next grant E18.
module rand_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic          clk,
    input  logic          reset,
    rand_arbiter_if.slave bus
);
    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t state, state_nx;

    logic [GW-1:0]    ptr, win, idx, gnt_q;
    logic             found, grant, last_step;
    logic [15:0]      lfsr, lfsr_nx, dividend;
    logic [WIDTH:0]   rem, span, span_nx, rem_sh, rem_step;
    logic [WIDTH-1:0] win_min, win_max, min_q, rnd_q;
    logic [N-1:0]     ack_q;
    logic             degen, busy_q;
    logic [3:0]       iter;

    // Round-robin pick: first set req at or above ptr, wrapping modulo N.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = GW'((int'(ptr) + k) % N);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_min = bus.min_flat[win*WIDTH +: WIDTH];
    assign win_max = bus.max_flat[win*WIDTH +: WIDTH];
    // WIDTH+1 bits so a full-range span (2^WIDTH) is representable.
    assign span_nx = {1'b0, win_max} - {1'b0, win_min} + (WIDTH+1)'(1);

    assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // rem < span <= 2^WIDTH, so the shifted value always fits in WIDTH+1 bits.
    assign rem_sh   = (rem << 1) | {{WIDTH{1'b0}}, dividend[15]};
    assign rem_step = (rem_sh >= span) ? (rem_sh - span) : rem_sh;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        last_step = 1'b0;
        unique case (state)
            IDLE: if (found) begin
                grant    = 1'b1;
                state_nx = DIV;
            end
            DIV: if (iter == 4'd15) begin
                last_step = 1'b1;
                state_nx  = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            lfsr     <= 16'hACE1;
            dividend <= '0;
            rem      <= '0;
            span     <= '0;
            min_q    <= '0;
            degen    <= 1'b0;
            iter     <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            rnd_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            ack_q  <= '0;
            // Stays high through the recovery IDLE cycle, so busy=0 means the
            // next edge can grant.
            busy_q <= grant | (state != IDLE);
            if (grant) begin
                gnt_q    <= win;
                ptr      <= (win == GW'(N - 1)) ? '0 : win + GW'(1);
                min_q    <= win_min;
                span     <= span_nx;
                degen    <= (win_max <= win_min);
                dividend <= lfsr;
                lfsr     <= lfsr_nx;
                rem      <= '0;
                iter     <= '0;
            end else if (state == DIV) begin
                rem      <= rem_step;
                dividend <= {dividend[14:0], 1'b0};
                iter     <= iter + 4'd1;
                if (last_step) begin
                    ack_q[gnt_q] <= 1'b1;
                    rnd_q        <= degen ? min_q : min_q + rem_step[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.ack     = ack_q;
    assign bus.rnd_out = rnd_q;
    assign bus.gnt_id  = gnt_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_rand_arbiter.sv
module tb_rand_arbiter;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rand_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus();
    rand_arbiter #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model state: the drawn value sequence and the rotation pointer.
    logic [15:0]  m_lfsr;
    int           m_ptr;
    int           rmin[N];
    int           rmax[N];
    logic [N-1:0] pend;

    typedef struct {
        int who;
        int mn;
        int mx;
        int exp_rnd;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [15:0] lf_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int exp_rnd(input int mn, input int mx, input logic [15:0] l);
        if (mx > mn) return mn + (int'(l) % (mx - mn + 1));
        return mn;
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_range(input int i, input int mn, input int mx);
        bus.min_flat[i*WIDTH +: WIDTH] = WIDTH'(mn);
        bus.max_flat[i*WIDTH +: WIDTH] = WIDTH'(mx);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        tick();
        tick();
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        m_ptr  = 0;
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output int lat);
        a   = '0;
        lat = 0;
        while (a == '0 && lat < 40) begin
            tick();
            lat++;
            a = bus.ack;
        end
    endtask

    // Wait for the next result and check it; pre = cycles already elapsed since
    // the request was presented to an idle arbiter.
    task automatic serve(input string nm, input int exp_id, input int exp_r,
                         input bit drop, input int pre);
        logic [N-1:0] a;
        int lat;
        wait_ack(a, lat);
        chk({nm, "_lat"}, lat + pre, 17);
        chk({nm, "_ack"}, int'(a), 1 << exp_id);
        chk({nm, "_id"}, int'(bus.gnt_id), exp_id);
        chk({nm, "_rnd"}, int'(bus.rnd_out), exp_r);
        tick();
        chk({nm, "_pulse"}, int'(bus.ack), 0);
        if (drop) bus.req = bus.req & ~a;
    endtask

    task automatic raise(input int i);
        int mn, mx;
        case ($urandom_range(0, 3))
            0: begin mn = 0; mx = 255; end
            1: begin mn = $urandom_range(0, 255); mx = mn; end
            2: begin mn = $urandom_range(0, 255); mx = $urandom_range(0, 255); end
            default: begin mn = $urandom_range(0, 250); mx = mn + $urandom_range(1, 5); end
        endcase
        rmin[i] = mn;
        rmax[i] = mx;
        set_range(i, mn, mx);
        pend[i] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc, na, got, w, e;
        bit prev_ack;

        bus.req      = '0;
        bus.min_flat = '0;
        bus.max_flat = '0;

        // Expected values worked by hand from the LFSR sequence
        // ACE1, 59C3, B387, 670F, CE1E, 9C3C, 3879.
        tbl[0] = '{0,   0,   9,   7};
        tbl[1] = '{0,   0,   9,   9};
        tbl[2] = '{1,   0, 255, 135};
        tbl[3] = '{2,   5,   2,   5};
        tbl[4] = '{3, 100, 199, 166};
        tbl[5] = '{0, 255, 255, 255};
        tbl[6] = '{1,   0, 254, 177};

        do_reset();
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_rnd", int'(bus.rnd_out), 0);
        chk("rst_gnt", int'(bus.gnt_id), 0);
        chk("rst_busy", int'(bus.busy), 0);

        for (int v = 0; v < 7; v++) begin
            set_range(tbl[v].who, tbl[v].mn, tbl[v].mx);
            bus.req = N'(1 << tbl[v].who);
            serve($sformatf("vec%0d", v), tbl[v].who, tbl[v].exp_rnd, 1'b1, 0);
        end

        // Full range: busy spans exactly 18 cycles, result = 0xE1.
        do_reset();
        set_range(0, 0, 255);
        bus.req  = 4'b0001;
        bc       = 0;
        na       = 0;
        got      = -1;
        prev_ack = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.busy) bc++;
            if (bus.ack[0]) begin
                na++;
                got = int'(bus.rnd_out);
            end
            if (prev_ack) bus.req = '0;
            prev_ack = bus.ack[0];
        end
        chk("busy_cycles", bc, 18);
        chk("busy_acks", na, 1);
        chk("busy_rnd", got, 225);

        // Narrow top-end range.
        do_reset();
        set_range(3, 250, 255);
        bus.req = 4'b1000;
        serve("hi3", 3, 251, 1'b1, 0);

        // Two requesters held together: strict alternation 0, 2, 0.
        do_reset();
        set_range(0, 0, 9);
        set_range(2, 0, 255);
        bus.req = 4'b0101;
        serve("rr0", 0, 7, 1'b0, 0);
        serve("rr1", 2, 195, 1'b0, 0);
        serve("rr2", 0, 9, 1'b0, 0);
        bus.req = '0;

        // Reset in the middle of a reduction: no ack, everything restarts.
        tick();
        bus.req = 4'b0100;
        tick();
        chk("mid_gnt", int'(bus.gnt_id), 2);
        bus.req = '0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_ack", int'(bus.ack), 0);
        chk("mid_rst_rnd", int'(bus.rnd_out), 0);
        chk("mid_rst_gnt", int'(bus.gnt_id), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        m_ptr  = 0;
        na     = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.ack != '0) na++;
        end
        chk("mid_no_ack", na, 0);
        set_range(0, 0, 9);
        bus.req = 4'b0001;
        serve("post", 0, 7, 1'b1, 0);

        // Random traffic against the reference model; the winner's range is
        // scribbled right after its grant edge and must not affect the result.
        do_reset();
        pend = '0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) raise(i);
            if (pend == '0) raise(t % N);
            bus.req = pend;
            w = pick(pend, m_ptr);
            e = exp_rnd(rmin[w], rmax[w], m_lfsr);
            m_lfsr = lf_next(m_lfsr);
            m_ptr  = (w + 1) % N;
            tick();
            set_range(w, $urandom_range(0, 255), $urandom_range(0, 255));
            serve($sformatf("rnd%0d", t), w, e, 1'b1, 1);
            pend[w] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
